hbfifo: RTL and testbench

- Parametrised successor to the two-entry hexbus skid buffer: a 2^LGDEPTH-entry FIFO with a registered output stage.
- Uses the same i_stb/o_busy (upstream) and o_stb/i_busy (downstream) handshake.
- Sits between hexbus stages (byte/word encoders, bus master, serial transmit) where rate mismatch exceeds one word of slack.
- Adds fill reporting and an optional synchronous flush.

---
 rtl/hbfifo.sv | 135 +++++++++++++
 tb/tb_hbfifo.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbfifo.sv
// hbfifo: 2^LGDEPTH-entry FIFO with a registered output stage for hexbus
// pipelines. Upstream handshake is i_stb/o_busy, downstream is o_stb/i_busy.
// Total capacity is 2^LGDEPTH memory words plus the output register.
// o_fill reports memory occupancy and excludes the output register.
//
// Optional feature: define HBFIFO_FLUSH_EN to add the i_flush port, a
// synchronous discard of everything held. Flush takes priority over
// accept, pop and reload.
module hbfifo #(
  parameter int W       = 8,
  parameter int LGDEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_stb,
  input  logic [W-1:0]       i_word,
  output logic               o_busy,
  output logic               o_stb,
  output logic [W-1:0]       o_word,
  input  logic               i_busy,
  output logic [LGDEPTH:0]   o_fill
`ifdef HBFIFO_FLUSH_EN
  ,
  input  logic               i_flush
`endif
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam int PW    = LGDEPTH + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fill_q, fill_d;
  logic          busy_q, busy_d;
  logic          stb_q, stb_d;
  logic [W-1:0]  word_q, word_d;

  logic flush;
  logic accept;
  logic out_free;
  logic mem_empty;
  logic do_write;
  logic do_reload;

`ifdef HBFIFO_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Handshake decode: what happens to the incoming word and the output stage.
  always_comb begin
    accept    = i_stb && !busy_q && !flush;
    out_free  = !stb_q || !i_busy;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    // A word skips memory only when memory is empty and the output can take it.
    do_write  = accept && !(mem_empty && out_free);
    do_reload = out_free && !mem_empty && !flush;
  end

  // Next-state for pointers, fill level, busy flag and the output stage.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    stb_d    = stb_q;
    word_d   = word_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      fill_d   = '0;
      stb_d    = 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_reload) begin
        // Oldest memory word moves to the output; a same-edge input queues behind it.
        rd_ptr_d = rd_ptr_q + PW'(1);
        stb_d    = 1'b1;
        word_d   = mem_q[rd_ptr_q[LGDEPTH-1:0]];
      end else if (out_free) begin
        // Memory empty here: either bypass the accepted word or drain.
        stb_d = accept;
        if (accept) begin
          word_d = i_word;
        end
      end
      case ({do_write, do_reload})
        2'b10:   fill_d = fill_q + PW'(1);
        2'b01:   fill_d = fill_q - PW'(1);
        default: fill_d = fill_q;
      endcase
    end
    // Busy is registered from the next fill level, so i_busy never reaches o_busy combinationally.
    busy_d = (fill_d == PW'(DEPTH));
  end

  // Control state registers, cleared by the asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      busy_q   <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      busy_q   <= busy_d;
      stb_q    <= stb_d;
    end
  end

  // Datapath storage: memory array and output word register.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is deliberately not reset; its contents are qualified by
    // the pointers and o_stb, and leaving it unreset keeps it mappable to RAM.
    if (do_write) begin
      mem_q[wr_ptr_q[LGDEPTH-1:0]] <= i_word;
    end
    word_q <= word_d;
  end

  assign o_busy = busy_q;
  assign o_stb  = stb_q;
  assign o_word = word_q;
  assign o_fill = fill_q;

endmodule

// File: tb/tb_hbfifo.sv
// Self-checking bench for hbfifo (W=8, LGDEPTH=2). A negedge monitor keeps a
// scoreboard: accepted words are queued, popped words are compared in order.
// Inputs change 1 time unit after each rising edge.
module tb_hbfifo;

  localparam int W       = 8;
  localparam int LGDEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             stb_i;
  logic [W-1:0]     word_i;
  logic             busy_i;
  logic             dut_busy;
  logic             dut_stb;
  logic [W-1:0]     dut_word;
  logic [LGDEPTH:0] dut_fill;
`ifdef HBFIFO_FLUSH_EN
  logic             flush_i;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int pop_count    = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_w;
  logic         hold_chk_en = 1'b0;
  logic         prev_hold   = 1'b0;
  logic [W-1:0] prev_word   = '0;

  hbfifo #(.W(W), .LGDEPTH(LGDEPTH)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_stb     (stb_i),
    .i_word    (word_i),
    .o_busy    (dut_busy),
    .o_stb     (dut_stb),
    .o_word    (dut_word),
    .i_busy    (busy_i),
    .o_fill    (dut_fill)
`ifdef HBFIFO_FLUSH_EN
    ,
    .i_flush   (flush_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: inputs and outputs here are exactly what the next rising edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      logic fl;
      fl = 1'b0;
`ifdef HBFIFO_FLUSH_EN
      fl = flush_i;
`endif
      if (hold_chk_en) begin
        if (prev_hold) begin
          tests_run++;
          if (dut_stb !== 1'b1 || dut_word !== prev_word) begin
            tests_failed++;
            $display("FAIL hold_stable: stb=%b word=%h, required stb=1 word=%h", dut_stb, dut_word, prev_word);
          end
        end
        tests_run++;
        if (dut_fill > 3'd4) begin
          tests_failed++;
          $display("FAIL fill_bound: fill=%0d, required <= 4", dut_fill);
        end
      end
      prev_hold = dut_stb && busy_i;
      prev_word = dut_word;
      if (fl) begin
        sb_q.delete();
      end else begin
        if (dut_stb && !busy_i) begin
          tests_run++;
          pop_count++;
          if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_order: got word %h, required no output (queue empty)", dut_word);
          end else begin
            exp_w = sb_q.pop_front();
            if (dut_word !== exp_w) begin
              tests_failed++;
              $display("FAIL sb_order: got %h, required %h", dut_word, exp_w);
            end
          end
        end
        if (stb_i && !dut_busy) sb_q.push_back(word_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the edge that accepts it (bounded).
  task automatic push_word(input logic [W-1:0] w);
    logic acc;
    stb_i  = 1'b1;
    word_i = w;
    for (int i = 0; i < 50; i++) begin
      acc = !dut_busy;
      tick();
      if (acc) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL push_timeout: word %h not accepted, required acceptance within 50 cycles", w);
  endtask

  // Let everything flow out and confirm the FIFO is empty.
  task automatic drain();
    stb_i  = 1'b0;
    busy_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!dut_stb && sb_q.size() == 0) break;
      tick();
    end
    tests_run++;
    if (dut_stb !== 1'b0 || sb_q.size() != 0 || dut_fill !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain: stb=%b fill=%0d pending=%0d, required 0 0 0", dut_stb, dut_fill, sb_q.size());
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (dut_stb !== 1'b0 || dut_busy !== 1'b0 || dut_fill !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_init: stb=%b busy=%b fill=%0d, required 0 0 0", dut_stb, dut_busy, dut_fill);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
    stb_i = 1'b0;
    tests_run++;
    if (dut_fill !== 3'd3 || dut_stb !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prefill: fill=%0d stb=%b, required 3 1", dut_fill, dut_stb);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (dut_stb !== 1'b0 || dut_busy !== 1'b0 || dut_fill !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_async: stb=%b busy=%b fill=%0d, required 0 0 0", dut_stb, dut_busy, dut_fill);
    end
    sb_q.delete();
    #1 rst_n = 1'b1;
    busy_i = 1'b0;
    stb_i  = 1'b1;
    word_i = 8'h33;
    tick();
    stb_i = 1'b0;
    tests_run++;
    if (dut_stb !== 1'b1 || dut_word !== 8'h33 || dut_fill !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_first: stb=%b word=%h fill=%0d, required 1 33 0", dut_stb, dut_word, dut_fill);
    end
    drain();
  endtask

  task automatic test_bypass();
    busy_i = 1'b0;
    push_word(8'hA5);
    stb_i = 1'b0;
    tests_run++;
    if (dut_stb !== 1'b1 || dut_word !== 8'hA5 || dut_fill !== 3'd0) begin
      tests_failed++;
      $display("FAIL bypass_out: stb=%b word=%h fill=%0d, required 1 a5 0", dut_stb, dut_word, dut_fill);
    end
    tick();
    tests_run++;
    if (dut_stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_drain: stb=%b, required 0", dut_stb);
    end
  endtask

  task automatic test_fill_full();
    logic [W-1:0] exp_seq [4] = '{8'h03, 8'h04, 8'h05, 8'h06};
    logic [2:0]   exp_fill [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    busy_i = 1'b1;
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    tests_run++;
    if (dut_busy !== 1'b1 || dut_fill !== 3'd4 || dut_word !== 8'h01 || dut_stb !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_set: busy=%b fill=%0d word=%h stb=%b, required 1 4 01 1", dut_busy, dut_fill, dut_word, dut_stb);
    end
    stb_i  = 1'b1;
    word_i = 8'h06;
    tick();
    tick();
    tests_run++;
    if (dut_busy !== 1'b1 || dut_fill !== 3'd4 || dut_word !== 8'h01) begin
      tests_failed++;
      $display("FAIL full_hold: busy=%b fill=%0d word=%h, required 1 4 01", dut_busy, dut_fill, dut_word);
    end
    busy_i = 1'b0;
    tick();
    tests_run++;
    if (dut_word !== 8'h02 || dut_busy !== 1'b0 || dut_fill !== 3'd3) begin
      tests_failed++;
      $display("FAIL full_release: word=%h busy=%b fill=%0d, required 02 0 3", dut_word, dut_busy, dut_fill);
    end
    tick();
    stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (dut_stb !== 1'b1 || dut_word !== exp_seq[i] || dut_fill !== exp_fill[i]) begin
        tests_failed++;
        $display("FAIL full_seq%0d: stb=%b word=%h fill=%0d, required 1 %h %0d", i, dut_stb, dut_word, dut_fill, exp_seq[i], exp_fill[i]);
      end
      tick();
    end
    tests_run++;
    if (dut_stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_end: stb=%b, required 0", dut_stb);
    end
  endtask

  task automatic test_back_to_back();
    busy_i = 1'b1;
    for (int i = 0; i < 3; i++) push_word(8'(8'h20 + i));
    stb_i = 1'b0;
    tests_run++;
    if (dut_fill !== 3'd2) begin
      tests_failed++;
      $display("FAIL steady_prefill: fill=%0d, required 2", dut_fill);
    end
    busy_i = 1'b0;
    stb_i  = 1'b1;
    word_i = 8'h40;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (dut_fill !== 3'd2 || dut_stb !== 1'b1) begin
        tests_failed++;
        $display("FAIL steady_c%0d: fill=%0d stb=%b, required 2 1", i, dut_fill, dut_stb);
      end
      word_i = word_i + 8'd1;
    end
    drain();
  endtask

  task automatic test_wrap();
    int   n       = 0;
    int   cyc     = 0;
    int   p0      = pop_count;
    logic holding = 1'b0;
    logic acc;
    stb_i       = 1'b0;
    prev_hold   = 1'b0;
    hold_chk_en = 1'b1;
    while (n < 40 && cyc < 2000) begin
      busy_i = 1'($urandom_range(0, 1));
      if (!holding) begin
        stb_i   = 1'($urandom_range(0, 1));
        word_i  = 8'(8'h80 + n);
        holding = stb_i;
      end
      acc = stb_i && !dut_busy;
      tick();
      cyc++;
      if (acc) begin
        n++;
        holding = 1'b0;
      end
    end
    drain();
    hold_chk_en = 1'b0;
    tests_run++;
    if (n != 40 || pop_count - p0 != 40) begin
      tests_failed++;
      $display("FAIL wrap_count: accepted=%0d popped=%0d, required 40 40", n, pop_count - p0);
    end
  endtask

`ifdef HBFIFO_FLUSH_EN
  task automatic test_flush();
    busy_i = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'h60 + i));
    tests_run++;
    if (dut_fill !== 3'd3 || dut_stb !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_prefill: fill=%0d stb=%b, required 3 1", dut_fill, dut_stb);
    end
    stb_i   = 1'b1;
    word_i  = 8'h77;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    stb_i   = 1'b0;
    tests_run++;
    if (dut_stb !== 1'b0 || dut_fill !== 3'd0 || dut_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: stb=%b fill=%0d busy=%b, required 0 0 0", dut_stb, dut_fill, dut_busy);
    end
    busy_i = 1'b0;
    tick();
    tick();
    tests_run++;
    if (dut_stb !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_dropped: stb=%b word=%h, required stb 0", dut_stb, dut_word);
    end
    push_word(8'h88);
    stb_i = 1'b0;
    tests_run++;
    if (dut_stb !== 1'b1 || dut_word !== 8'h88) begin
      tests_failed++;
      $display("FAIL flush_after: stb=%b word=%h, required 1 88", dut_stb, dut_word);
    end
    drain();
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    stb_i  = 1'b0;
    word_i = '0;
    busy_i = 1'b0;
`ifdef HBFIFO_FLUSH_EN
    flush_i = 1'b0;
`endif
    #2;
    test_reset();
    test_bypass();
    test_fill_full();
    test_back_to_back();
    test_wrap();
`ifdef HBFIFO_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
